// File: rtl/wb_mem_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone B4 classic arbiter with
// round-robin tie breaking, whole-cycle bus lock and a per-transfer ack watchdog.
//
// state  | meaning
// IDLE   | no master owns the slave, all s_* outputs are 0
// GNT_I  | instruction port owns the slave while iwb_cyc_i is high
// GNT_D  | data port owns the slave while dwb_cyc_i is high
module wb_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] iwb_adr_i,
    input  logic              iwb_cyc_i,
    input  logic              iwb_stb_i,
    output logic [31:0]       iwb_dat_o,
    output logic              iwb_ack_o,
    output logic              iwb_err_o,
    input  logic [ADDR_W-1:0] dwb_adr_i,
    input  logic [31:0]       dwb_dat_i,
    input  logic              dwb_we_i,
    input  logic [3:0]        dwb_sel_i,
    input  logic              dwb_cyc_i,
    input  logic              dwb_stb_i,
    output logic [31:0]       dwb_dat_o,
    output logic              dwb_ack_o,
    output logic              dwb_err_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [31:0]       s_dat_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [31:0]       s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    output logic [1:0]        grant_o
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_I = 2'b01;
    localparam logic [1:0] GNT_D = 2'b10;

    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic        TO_EN   = (TIMEOUT != 0);

    logic [1:0]  state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;

    logic gnt_i, gnt_d, grant_chg, timeout_hit, ack_fwd, err_fwd;

    assign gnt_i = (state_q == GNT_I);
    assign gnt_d = (state_q == GNT_D);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (iwb_cyc_i && dwb_cyc_i) state_d = last_d_q ? GNT_I : GNT_D;
                else if (iwb_cyc_i)         state_d = GNT_I;
                else if (dwb_cyc_i)         state_d = GNT_D;
            end
            GNT_I: begin
                if (!iwb_cyc_i) state_d = dwb_cyc_i ? GNT_D : IDLE;
            end
            GNT_D: begin
                if (!dwb_cyc_i) state_d = iwb_cyc_i ? GNT_I : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_chg = (state_d != state_q);

    always_comb begin
        last_d_d = last_d_q;
        if (grant_chg && state_d == GNT_D) last_d_d = 1'b1;
        if (grant_chg && state_d == GNT_I) last_d_d = 1'b0;
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = 4'h0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (gnt_i) begin
            s_adr_o = iwb_adr_i;
            s_sel_o = 4'hF;
            s_cyc_o = iwb_cyc_i;
            s_stb_o = iwb_stb_i;
        end else if (gnt_d) begin
            s_adr_o = dwb_adr_i;
            s_dat_o = dwb_dat_i;
            s_we_o  = dwb_we_i;
            s_sel_o = dwb_sel_i;
            s_cyc_o = dwb_cyc_i;
            s_stb_o = dwb_stb_i;
        end
    end

    // A real slave response always beats the watchdog; err beats ack.
    assign timeout_hit = TO_EN && s_stb_o && (wd_cnt_q == TO_LAST) && !s_ack_i && !s_err_i;
    assign err_fwd     = s_err_i || timeout_hit;
    assign ack_fwd     = s_ack_i && !s_err_i;

    always_comb begin
        wd_cnt_d = wd_cnt_q + 16'd1;
        if (!s_stb_o || s_ack_i || s_err_i || grant_chg || timeout_hit) wd_cnt_d = 16'd0;
    end

    assign iwb_ack_o = gnt_i && ack_fwd;
    assign iwb_err_o = gnt_i && err_fwd;
    assign dwb_ack_o = gnt_d && ack_fwd;
    assign dwb_err_o = gnt_d && err_fwd;

    // Read data is gated in IDLE so the whole interface is quiet right after reset.
    assign iwb_dat_o = (gnt_i || gnt_d) ? s_dat_i : 32'h0;
    assign dwb_dat_o = (gnt_i || gnt_d) ? s_dat_i : 32'h0;
    assign grant_o   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            wd_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule
